hazard_sequencer: RTL and testbench

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

---
 rtl/hazard_sequencer_pkg.sv | 48 ++++
 rtl/hazard_sequencer_if.sv | 49 ++++
 rtl/sat_counter.sv | 40 ++++
 rtl/hazard_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_hazard_sequencer.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// hazard_sequencer_pkg
// Shared pipeline-control definitions used by the hazard sequencer: the FSM
// state encoding, the default memory timeout, the widths of the wait and
// statistics counters, and the control-word type with its canned values.
// No ports (package).
// -----------------------------------------------------------------------------
package hazard_sequencer_pkg;

   localparam int unsigned REG_ADDR_W      = 5;
   localparam int unsigned WAIT_CNT_W      = 8;
   localparam int unsigned STALL_CNT_W     = 32;
   localparam int unsigned FLUSH_CNT_W     = 16;
   localparam int unsigned TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DWAIT = 2'd1,
      ST_IWAIT = 2'd2,
      ST_ERR   = 2'd3
   } state_e;

   // One control word drives every pipeline-register enable in a cycle.
   typedef struct packed {
      logic pc_we;
      logic stall_ifid;
      logic stall_idexe;
      logic stall_exemem;
      logic stall_memwb;
      logic flush_ifid;
      logic flush_idexe;
      logic error;
   } ctl_t;

   // Free-running pipeline.
   localparam ctl_t CTL_RUN      = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   // Freeze the whole pipeline while the data memory is busy.
   localparam ctl_t CTL_HOLD_ALL = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   // Load-use: keep the consumer in ID, send a bubble into EXE.
   localparam ctl_t CTL_BUBBLE   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   // Fetch miss: hold PC, bubble into ID, let the older instructions drain.
   localparam ctl_t CTL_FETCH    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   // Taken branch without delay slot: squash the wrong-path fetch.
   localparam ctl_t CTL_BRANCH   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   // Memory timeout: freeze everything and flag the error.
   localparam ctl_t CTL_ERROR    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

endpackage : hazard_sequencer_pkg

// File: rtl/hazard_sequencer_if.sv
// -----------------------------------------------------------------------------
// hazard_sequencer_if
// Bundle of the signals exchanged between the pipeline datapath and the
// hazard sequencer.
//   master : pipeline side, drives hazard inputs, receives stall/flush/stats
//   slave  : controller side, the mirror image
// -----------------------------------------------------------------------------
interface hazard_sequencer_if;
   import hazard_sequencer_pkg::*;

   logic [REG_ADDR_W-1:0]  id_rs;
   logic [REG_ADDR_W-1:0]  id_rt;
   logic                   id_uses_rs;
   logic                   id_uses_rt;
   logic                   idexe_memread;
   logic                   idexe_we;
   logic [REG_ADDR_W-1:0]  idexe_wreg;
   logic                   branch_taken;
   logic                   exemem_memacc;
   logic                   dmem_ready;
   logic                   imem_ready;
   logic                   pc_we;
   logic                   stall_ifid;
   logic                   stall_idexe;
   logic                   stall_exemem;
   logic                   stall_memwb;
   logic                   flush_ifid;
   logic                   flush_idexe;
   logic                   error;
   logic [STALL_CNT_W-1:0] stall_cycles;
   logic [FLUSH_CNT_W-1:0] flush_count;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt,
      output idexe_memread, idexe_we, idexe_wreg,
      output branch_taken, exemem_memacc, dmem_ready, imem_ready,
      input  pc_we, stall_ifid, stall_idexe, stall_exemem, stall_memwb,
      input  flush_ifid, flush_idexe, error, stall_cycles, flush_count
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt,
      input  idexe_memread, idexe_we, idexe_wreg,
      input  branch_taken, exemem_memacc, dmem_ready, imem_ready,
      output pc_we, stall_ifid, stall_idexe, stall_exemem, stall_memwb,
      output flush_ifid, flush_idexe, error, stall_cycles, flush_count
   );

endinterface : hazard_sequencer_if

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that increments when enabled and sticks at all-ones.
//   CLOCK   : clock
//   RESET   : asynchronous, active-low reset (count cleared)
//   inc_i   : count this cycle
//   count_o : current count
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule : sat_counter

// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
// Pipeline hazard controller for a 5-stage in-order core. Detects load-use
// hazards, data/instruction memory misses and taken branches, and drives the
// PC enable plus per-register stall/flush controls. Memory waits are tracked
// by a RUN/DWAIT/IWAIT/ERR FSM with a timeout into a sticky error state.
//   CLOCK, RESET                      : clock, async active-low reset
//   ID_RS/RT, ID_USES_RS/RT           : source operands of the ID instruction
//   IDEXE_MEMREAD/WE/WREG             : producer held in ID/EXE
//   BRANCH_TAKEN                      : ID resolved a taken branch/jump
//   EXEMEM_MEMACC                     : MEM stage accesses data memory
//   DMEM_READY, IMEM_READY            : memory completion strobes
//   PC_WE, STALL_*, FLUSH_*           : pipeline register controls
//   ERROR                             : sticky memory timeout
//   STALL_CYCLES, FLUSH_COUNT         : saturating statistics
// -----------------------------------------------------------------------------
module hazard_sequencer
   import hazard_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT,
   parameter bit          DELAY_SLOT = 1'b1
) (
   input  logic                   CLOCK,
   input  logic                   RESET,
   input  logic [REG_ADDR_W-1:0]  ID_RS,
   input  logic [REG_ADDR_W-1:0]  ID_RT,
   input  logic                   ID_USES_RS,
   input  logic                   ID_USES_RT,
   input  logic                   IDEXE_MEMREAD,
   input  logic                   IDEXE_WE,
   input  logic [REG_ADDR_W-1:0]  IDEXE_WREG,
   input  logic                   BRANCH_TAKEN,
   input  logic                   EXEMEM_MEMACC,
   input  logic                   DMEM_READY,
   input  logic                   IMEM_READY,
   output logic                   PC_WE,
   output logic                   STALL_IFID,
   output logic                   STALL_IDEXE,
   output logic                   STALL_EXEMEM,
   output logic                   STALL_MEMWB,
   output logic                   FLUSH_IFID,
   output logic                   FLUSH_IDEXE,
   output logic                   ERROR,
   output logic [STALL_CNT_W-1:0] STALL_CYCLES,
   output logic [FLUSH_CNT_W-1:0] FLUSH_COUNT
);

   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(TIMEOUT);

   state_e                state_q;
   state_e                state_d;
   logic [WAIT_CNT_W-1:0] wait_cnt_q;
   logic [WAIT_CNT_W-1:0] wait_cnt_d;

   logic rs_hit;
   logic rt_hit;
   logic load_use;
   logic data_miss;
   logic inst_miss;
   logic branch_flush;
   logic timed_out;
   ctl_t run_ctl;
   ctl_t ctl;

   // ---------------------------------------------------------------------------
   // Event detection. Register 0 is hard-wired, so a load into it never
   // creates a dependency.
   // ---------------------------------------------------------------------------
   assign rs_hit       = ID_USES_RS && (ID_RS == IDEXE_WREG);
   assign rt_hit       = ID_USES_RT && (ID_RT == IDEXE_WREG);
   assign load_use     = IDEXE_MEMREAD && IDEXE_WE && (IDEXE_WREG != '0) &&
                         (rs_hit || rt_hit);
   assign data_miss    = EXEMEM_MEMACC && !DMEM_READY;
   assign inst_miss    = !IMEM_READY;
   assign branch_flush = BRANCH_TAKEN && !DELAY_SLOT;
   assign timed_out    = (wait_cnt_q == TIMEOUT_CNT);

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: the reset is asynchronous, so RESET sits in the sensitivity list
   // and clears the FSM without waiting for a clock edge.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            // A load-use bubble outranks a fetch miss; the miss is taken up
            // again next cycle once the bubble has gone through.
            if (data_miss) begin
               state_d = ST_DWAIT;
            end else if (!load_use && inst_miss) begin
               state_d = ST_IWAIT;
            end
         end
         ST_DWAIT: begin
            if (DMEM_READY) begin
               state_d = ST_RUN;
            end else if (timed_out) begin
               state_d = ST_ERR;
            end
         end
         ST_IWAIT: begin
            if (data_miss) begin
               state_d = ST_DWAIT;
            end else if (IMEM_READY) begin
               state_d = ST_RUN;
            end else if (timed_out) begin
               state_d = ST_ERR;
            end
         end
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_RUN;
      endcase

      // Counter restarts at zero on any entry into a wait state (including
      // IWAIT -> DWAIT) and counts every further cycle spent there.
      wait_cnt_d = '0;
      if ((state_d == ST_DWAIT) || (state_d == ST_IWAIT)) begin
         if (state_d == state_q) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output logic: combinational so a hazard acts in the cycle it is seen.
   // ---------------------------------------------------------------------------
   always_comb begin
      run_ctl = CTL_RUN;
      if (data_miss) begin
         run_ctl = CTL_HOLD_ALL;
      end else if (load_use) begin
         run_ctl = CTL_BUBBLE;
      end else if (inst_miss) begin
         run_ctl = CTL_FETCH;
      end else if (branch_flush) begin
         run_ctl = CTL_BRANCH;
      end

      ctl = run_ctl;
      case (state_q)
         // The READY cycle itself already runs normally.
         ST_DWAIT: ctl = DMEM_READY ? run_ctl : CTL_HOLD_ALL;
         ST_ERR:   ctl = CTL_ERROR;
         default:  ctl = run_ctl;
      endcase
   end

   assign PC_WE        = ctl.pc_we;
   assign STALL_IFID   = ctl.stall_ifid;
   assign STALL_IDEXE  = ctl.stall_idexe;
   assign STALL_EXEMEM = ctl.stall_exemem;
   assign STALL_MEMWB  = ctl.stall_memwb;
   assign FLUSH_IFID   = ctl.flush_ifid;
   assign FLUSH_IDEXE  = ctl.flush_idexe;
   assign ERROR        = ctl.error;

   // ---------------------------------------------------------------------------
   // Statistics
   // ---------------------------------------------------------------------------
   sat_counter #(
      .WIDTH (STALL_CNT_W)
   ) u_stall_cnt (
      .CLOCK   (CLOCK),
      .RESET   (RESET),
      .inc_i   (!ctl.pc_we),
      .count_o (STALL_CYCLES)
   );

   sat_counter #(
      .WIDTH (FLUSH_CNT_W)
   ) u_flush_cnt (
      .CLOCK   (CLOCK),
      .RESET   (RESET),
      .inc_i   (ctl.flush_ifid || ctl.flush_idexe),
      .count_o (FLUSH_COUNT)
   );

endmodule : hazard_sequencer

// File: tb/tb_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hazard_sequencer
// Directed bench for hazard_sequencer. dut0 has DELAY_SLOT=0 and TIMEOUT=4,
// dut1 has DELAY_SLOT=1 and the default TIMEOUT; both see the same inputs.
// Inputs change and outputs are sampled just after the falling clock edge.
// Control word order: {PC_WE, STALL_IFID, STALL_IDEXE, STALL_EXEMEM,
//                      STALL_MEMWB, FLUSH_IFID, FLUSH_IDEXE, ERROR}
// -----------------------------------------------------------------------------
module tb_hazard_sequencer;
   import hazard_sequencer_pkg::*;

   localparam logic [7:0] E_RUN   = 8'b1000_0000;
   localparam logic [7:0] E_LU    = 8'b0100_0010;
   localparam logic [7:0] E_DMISS = 8'b0111_1000;
   localparam logic [7:0] E_IMISS = 8'b0000_0100;
   localparam logic [7:0] E_BR    = 8'b1000_0100;
   localparam logic [7:0] E_ERR   = 8'b0111_1001;

   logic CLOCK = 1'b0;
   logic RESET = 1'b0;
   always #5 CLOCK = ~CLOCK;

   hazard_sequencer_if bus ();

   logic        w1_pc_we, w1_stall_ifid, w1_stall_idexe, w1_stall_exemem;
   logic        w1_stall_memwb, w1_flush_ifid, w1_flush_idexe, w1_error;
   logic [31:0] w1_stall_cycles;
   logic [15:0] w1_flush_count;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   hazard_sequencer #(.TIMEOUT(4), .DELAY_SLOT(1'b0)) dut0 (
      .CLOCK         (CLOCK),
      .RESET         (RESET),
      .ID_RS         (bus.id_rs),
      .ID_RT         (bus.id_rt),
      .ID_USES_RS    (bus.id_uses_rs),
      .ID_USES_RT    (bus.id_uses_rt),
      .IDEXE_MEMREAD (bus.idexe_memread),
      .IDEXE_WE      (bus.idexe_we),
      .IDEXE_WREG    (bus.idexe_wreg),
      .BRANCH_TAKEN  (bus.branch_taken),
      .EXEMEM_MEMACC (bus.exemem_memacc),
      .DMEM_READY    (bus.dmem_ready),
      .IMEM_READY    (bus.imem_ready),
      .PC_WE         (bus.pc_we),
      .STALL_IFID    (bus.stall_ifid),
      .STALL_IDEXE   (bus.stall_idexe),
      .STALL_EXEMEM  (bus.stall_exemem),
      .STALL_MEMWB   (bus.stall_memwb),
      .FLUSH_IFID    (bus.flush_ifid),
      .FLUSH_IDEXE   (bus.flush_idexe),
      .ERROR         (bus.error),
      .STALL_CYCLES  (bus.stall_cycles),
      .FLUSH_COUNT   (bus.flush_count)
   );

   hazard_sequencer #(.DELAY_SLOT(1'b1)) dut1 (
      .CLOCK         (CLOCK),
      .RESET         (RESET),
      .ID_RS         (bus.id_rs),
      .ID_RT         (bus.id_rt),
      .ID_USES_RS    (bus.id_uses_rs),
      .ID_USES_RT    (bus.id_uses_rt),
      .IDEXE_MEMREAD (bus.idexe_memread),
      .IDEXE_WE      (bus.idexe_we),
      .IDEXE_WREG    (bus.idexe_wreg),
      .BRANCH_TAKEN  (bus.branch_taken),
      .EXEMEM_MEMACC (bus.exemem_memacc),
      .DMEM_READY    (bus.dmem_ready),
      .IMEM_READY    (bus.imem_ready),
      .PC_WE         (w1_pc_we),
      .STALL_IFID    (w1_stall_ifid),
      .STALL_IDEXE   (w1_stall_idexe),
      .STALL_EXEMEM  (w1_stall_exemem),
      .STALL_MEMWB   (w1_stall_memwb),
      .FLUSH_IFID    (w1_flush_ifid),
      .FLUSH_IDEXE   (w1_flush_idexe),
      .ERROR         (w1_error),
      .STALL_CYCLES  (w1_stall_cycles),
      .FLUSH_COUNT   (w1_flush_count)
   );

   function automatic logic [7:0] ctl0();
      return {bus.pc_we, bus.stall_ifid, bus.stall_idexe, bus.stall_exemem,
              bus.stall_memwb, bus.flush_ifid, bus.flush_idexe, bus.error};
   endfunction

   function automatic logic [7:0] ctl1();
      return {w1_pc_we, w1_stall_ifid, w1_stall_idexe, w1_stall_exemem,
              w1_stall_memwb, w1_flush_ifid, w1_flush_idexe, w1_error};
   endfunction

   task automatic set_idle();
      bus.id_rs         = 5'd0;
      bus.id_rt         = 5'd0;
      bus.id_uses_rs    = 1'b0;
      bus.id_uses_rt    = 1'b0;
      bus.idexe_memread = 1'b0;
      bus.idexe_we      = 1'b0;
      bus.idexe_wreg    = 5'd0;
      bus.branch_taken  = 1'b0;
      bus.exemem_memacc = 1'b0;
      bus.dmem_ready    = 1'b1;
      bus.imem_ready    = 1'b1;
   endtask

   task automatic set_load_use(input logic [4:0] wreg, input logic [4:0] rs,
                               input logic [4:0] rt, input logic use_rs,
                               input logic use_rt);
      bus.idexe_memread = 1'b1;
      bus.idexe_we      = 1'b1;
      bus.idexe_wreg    = wreg;
      bus.id_rs         = rs;
      bus.id_rt         = rt;
      bus.id_uses_rs    = use_rs;
      bus.id_uses_rt    = use_rt;
   endtask

   // Counter comparison for dut0 against the running hand-tallied totals.
   task automatic test_counts(input string tag);
      n_checks++;
      if (bus.stall_cycles !== 32'(exp_stall)) begin
         n_fail++;
         $display("FAIL %s stall_cycles got %0d want %0d", tag, bus.stall_cycles, exp_stall);
      end
      n_checks++;
      if (bus.flush_count !== 16'(exp_flush)) begin
         n_fail++;
         $display("FAIL %s flush_count got %0d want %0d", tag, bus.flush_count, exp_flush);
      end
   endtask

   task automatic test_reset();
      set_idle();
      RESET = 1'b0;
      repeat (2) @(negedge CLOCK);
      #1;
      n_checks++;
      if (ctl0() !== E_RUN) begin
         n_fail++;
         $display("FAIL reset_ctl got %b want %b", ctl0(), E_RUN);
      end
      n_checks++;
      if (dut0.state_q !== ST_RUN) begin
         n_fail++;
         $display("FAIL reset_state got %0d want %0d", dut0.state_q, ST_RUN);
      end
      exp_stall = 0;
      exp_flush = 0;
      test_counts("reset");
      @(negedge CLOCK);
      RESET = 1'b1;
      @(negedge CLOCK);
      #1;
      n_checks++;
      if (ctl0() !== E_RUN) begin
         n_fail++;
         $display("FAIL post_reset_ctl got %b want %b", ctl0(), E_RUN);
      end
   endtask

   task automatic test_load_use();
      @(negedge CLOCK);
      set_load_use(5'd8, 5'd8, 5'd0, 1'b1, 1'b0);
      #1;
      n_checks++;
      if (ctl0() !== E_LU) begin
         n_fail++;
         $display("FAIL load_use_rs got %b want %b", ctl0(), E_LU);
      end
      n_checks++;
      if (ctl1() !== E_LU) begin
         n_fail++;
         $display("FAIL load_use_rs_dut1 got %b want %b", ctl1(), E_LU);
      end
      @(negedge CLOCK);
      set_idle();
      #1;
      n_checks++;
      if (ctl0() !== E_RUN) begin
         n_fail++;
         $display("FAIL load_use_after got %b want %b", ctl0(), E_RUN);
      end
      n_checks++;
      if (dut0.state_q !== ST_RUN) begin
         n_fail++;
         $display("FAIL load_use_state got %0d want %0d", dut0.state_q, ST_RUN);
      end
      exp_stall = 1;
      exp_flush = 1;
      test_counts("load_use");
      // Matching register but the ID instruction does not read it.
      set_load_use(5'd8, 5'd8, 5'd8, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (ctl0() !== E_RUN) begin
         n_fail++;
         $display("FAIL load_use_unused got %b want %b", ctl0(), E_RUN);
      end
      // Producer is not a load.
      set_load_use(5'd8, 5'd8, 5'd0, 1'b1, 1'b0);
      bus.idexe_memread = 1'b0;
      #1;
      n_checks++;
      if (ctl0() !== E_RUN) begin
         n_fail++;
         $display("FAIL load_use_noload got %b want %b", ctl0(), E_RUN);
      end
      set_idle();
   endtask

   task automatic test_reg0();
      @(negedge CLOCK);
      set_load_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      #1;
      n_checks++;
      if (ctl0() !== E_RUN) begin
         n_fail++;
         $display("FAIL reg0_load got %b want %b", ctl0(), E_RUN);
      end
      @(negedge CLOCK);
      set_idle();
      #1;
      test_counts("reg0");
   endtask

   task automatic test_back_to_back();
      @(negedge CLOCK);
      set_load_use(5'd3, 5'd3, 5'd9, 1'b1, 1'b1);
      #1;
      n_checks++;
      if (ctl0() !== E_LU) begin
         n_fail++;
         $display("FAIL b2b_first got %b want %b", ctl0(), E_LU);
      end
      @(negedge CLOCK);
      set_load_use(5'd17, 5'd2, 5'd17, 1'b1, 1'b1);
      #1;
      n_checks++;
      if (ctl0() !== E_LU) begin
         n_fail++;
         $display("FAIL b2b_second_rt got %b want %b", ctl0(), E_LU);
      end
      @(negedge CLOCK);
      set_idle();
      #1;
      exp_stall += 2;
      exp_flush += 2;
      test_counts("b2b");
   endtask

   task automatic test_inst_miss();
      @(negedge CLOCK);
      bus.imem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_checks++;
         if (ctl0() !== E_IMISS) begin
            n_fail++;
            $display("FAIL imiss_cycle%0d got %b want %b", i, ctl0(), E_IMISS);
         end
         @(negedge CLOCK);
      end
      #1;
      n_checks++;
      if (dut0.state_q !== ST_IWAIT) begin
         n_fail++;
         $display("FAIL imiss_state got %0d want %0d", dut0.state_q, ST_IWAIT);
      end
      bus.imem_ready = 1'b1;
      #1;
      n_checks++;
      if (ctl0() !== E_RUN) begin
         n_fail++;
         $display("FAIL imiss_ready_cycle got %b want %b", ctl0(), E_RUN);
      end
      @(negedge CLOCK);
      #1;
      n_checks++;
      if (dut0.state_q !== ST_RUN) begin
         n_fail++;
         $display("FAIL imiss_return got %0d want %0d", dut0.state_q, ST_RUN);
      end
      exp_stall += 2;
      exp_flush += 2;
      test_counts("imiss");

      // Data miss while waiting on the fetch wins and moves to DWAIT.
      bus.imem_ready = 1'b0;
      @(negedge CLOCK);
      bus.exemem_memacc = 1'b1;
      bus.dmem_ready    = 1'b0;
      #1;
      n_checks++;
      if (ctl0() !== E_DMISS) begin
         n_fail++;
         $display("FAIL iwait_dmiss got %b want %b", ctl0(), E_DMISS);
      end
      @(negedge CLOCK);
      #1;
      n_checks++;
      if (dut0.state_q !== ST_DWAIT) begin
         n_fail++;
         $display("FAIL iwait_to_dwait got %0d want %0d", dut0.state_q, ST_DWAIT);
      end
      @(negedge CLOCK);
      set_idle();
      @(negedge CLOCK);
      #1;
      exp_stall += 3;
      exp_flush += 1;
      test_counts("iwait_dmiss");
   endtask

   task automatic test_data_miss();
      @(negedge CLOCK);
      set_load_use(5'd8, 5'd8, 5'd0, 1'b1, 1'b0);
      bus.imem_ready    = 1'b0;
      bus.exemem_memacc = 1'b1;
      bus.dmem_ready    = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++;
         if (ctl0() !== E_DMISS) begin
            n_fail++;
            $display("FAIL dmiss_cycle%0d got %b want %b", i, ctl0(), E_DMISS);
         end
         @(negedge CLOCK);
      end
      set_idle();
      #1;
      n_checks++;
      if ((ctl0() !== E_RUN) || (dut0.state_q !== ST_DWAIT)) begin
         n_fail++;
         $display("FAIL dmiss_ready_cycle got %b/%0d want %b/%0d",
                  ctl0(), dut0.state_q, E_RUN, ST_DWAIT);
      end
      @(negedge CLOCK);
      #1;
      n_checks++;
      if (dut0.state_q !== ST_RUN) begin
         n_fail++;
         $display("FAIL dmiss_return got %0d want %0d", dut0.state_q, ST_RUN);
      end
      exp_stall += 5;
      test_counts("dmiss");
   endtask

   task automatic test_timeout();
      @(negedge CLOCK);
      bus.exemem_memacc = 1'b1;
      bus.dmem_ready    = 1'b0;
      // Miss cycle in RUN plus DWAIT with wait counter 0..4: still no error.
      for (int i = 0; i < 6; i++) begin
         #1;
         n_checks++;
         if (bus.error !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early%0d error got %b want 0", i, bus.error);
         end
         @(negedge CLOCK);
      end
      #1;
      n_checks++;
      if (ctl0() !== E_ERR) begin
         n_fail++;
         $display("FAIL timeout_err got %b want %b", ctl0(), E_ERR);
      end
      n_checks++;
      if (ctl1() !== E_DMISS) begin
         n_fail++;
         $display("FAIL timeout_dut1_waiting got %b want %b", ctl1(), E_DMISS);
      end
      set_idle();
      @(negedge CLOCK);
      #1;
      n_checks++;
      if (ctl0() !== E_ERR) begin
         n_fail++;
         $display("FAIL err_sticky got %b want %b", ctl0(), E_ERR);
      end
      n_checks++;
      if (ctl1() !== E_RUN) begin
         n_fail++;
         $display("FAIL dut1_recovered got %b want %b", ctl1(), E_RUN);
      end
      RESET = 1'b0;
      #1;
      n_checks++;
      if ((ctl0() !== E_RUN) || (dut0.state_q !== ST_RUN)) begin
         n_fail++;
         $display("FAIL err_reset got %b/%0d want %b/%0d",
                  ctl0(), dut0.state_q, E_RUN, ST_RUN);
      end
      exp_stall = 0;
      exp_flush = 0;
      test_counts("err_reset");
      @(negedge CLOCK);
      RESET = 1'b1;
   endtask

   task automatic test_branch();
      @(negedge CLOCK);
      bus.branch_taken = 1'b1;
      #1;
      n_checks++;
      if (ctl0() !== E_BR) begin
         n_fail++;
         $display("FAIL branch_ds0 got %b want %b", ctl0(), E_BR);
      end
      n_checks++;
      if (ctl1() !== E_RUN) begin
         n_fail++;
         $display("FAIL branch_ds1 got %b want %b", ctl1(), E_RUN);
      end
      @(negedge CLOCK);
      set_idle();
      #1;
      exp_flush = 1;
      test_counts("branch");
      n_checks++;
      if (w1_flush_count !== 16'd0) begin
         n_fail++;
         $display("FAIL branch_ds1_count got %0d want 0", w1_flush_count);
      end
      // Fetch miss outranks the branch.
      bus.branch_taken = 1'b1;
      bus.imem_ready   = 1'b0;
      #1;
      n_checks++;
      if (ctl0() !== E_IMISS) begin
         n_fail++;
         $display("FAIL branch_vs_imiss got %b want %b", ctl0(), E_IMISS);
      end
      @(negedge CLOCK);
      set_idle();
      @(negedge CLOCK);
   endtask

   task automatic test_saturation();
      RESET = 1'b0;
      @(negedge CLOCK);
      RESET = 1'b1;
      bus.branch_taken = 1'b1;
      repeat (65535) @(negedge CLOCK);
      #1;
      n_checks++;
      if (bus.flush_count !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL sat_reach got %h want ffff", bus.flush_count);
      end
      repeat (2) @(negedge CLOCK);
      #1;
      n_checks++;
      if (bus.flush_count !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL sat_hold got %h want ffff", bus.flush_count);
      end
      n_checks++;
      if ((bus.stall_cycles !== 32'd0) || (w1_flush_count !== 16'd0)) begin
         n_fail++;
         $display("FAIL sat_side got stall %0d ds1_flush %0d want 0 0",
                  bus.stall_cycles, w1_flush_count);
      end
      set_idle();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_reg0();
      test_back_to_back();
      test_inst_miss();
      test_data_miss();
      test_timeout();
      test_branch();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_hazard_sequencer
